imem_boot_ctrl: RTL

- Synthesizable boot controller for the single-cycle MIPS core.
- Replaces the bench-only file preload and fixed reset pulse with a streamed word loader plus a reset sequencer.
- Accepts instruction words over a valid/ready stream and writes them into the instruction memory's write port.
- Holds the CPU in reset for a programmable number of cycles after the last word, then releases it; supports reload and overflow detection.

---
 rtl/imem_boot_ctrl_if.sv | 12 +
 rtl/imem_boot_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Valid/ready stream that carries the boot image into the controller.
interface imem_boot_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot controller: streams an instruction image into imem, then sequences the CPU reset.
//
// state | meaning
// IDLE  | after reset, CPU held in reset, waiting for start
// LOAD  | accepting words, one imem write per accepted word
// HOLD  | image complete, CPU still in reset for RST_HOLD cycles
// RUN   | CPU released, done asserted
// ERR   | image overflowed imem, CPU held in reset until start
module imem_boot_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RST_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  imem_boot_ctrl_if.slave   load,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [7:0]        HOLD_INIT = 8'(RST_HOLD - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  assign load.load_ready = (state_q == S_LOAD);
  assign accept          = load.load_ready & load.load_valid;
  assign imem_we_o       = accept;
  assign imem_addr_o     = ptr_q;
  assign imem_wdata_o    = load.load_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start_i) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_ONE;
          // Pointer saturates at the top word so it can never wrap to 0.
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + PTR_ONE;
          end
          if (load.load_last) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end else if (ptr_q == PTR_MAX) begin
            state_d = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies decoded from the next state.
    cpu_rst_d = (state_d != S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_HOLD);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
  end

  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = cnt_q;

endmodule
